// File: rtl/ifu_pkg.sv
// Shared constants and types for the instruction fetch unit.
package ifu_pkg;

  localparam logic [31:0] INST_NOP     = 32'h0000_0013;
  localparam logic [31:0] IFU_RESET_PC = 32'h0000_0000;

  // Execute's PC select encoding; redirect corresponds to PC_JUMP.
  typedef enum logic {
    PC_PLUS4 = 1'b0,
    PC_JUMP  = 1'b1
  } pcsel_e;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HALT  = 1'b1
  } ifu_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous instruction FIFO holding {pc, word}; flush overrides push and pop.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_push = push & (!full | pop);
  assign do_pop  = pop & !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!flush && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: credit-limited in-order fetch, word buffer toward
// decode, and redirect handling with dropping of wrong-path responses.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc4,
  output logic        misaligned
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Handshakes: a transfer happens on a cycle where valid and ready are both
  // high at the rising edge; valid never depends on ready of the same port.

  ifu_state_e   state, state_next;
  logic         armed;
  logic [31:0]  fpc;
  logic [31:0]  rsp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] fifo_count;
  logic         fifo_empty;
  logic         fifo_full;
  fetch_entry_t head;
  fetch_entry_t push_entry;
  logic         credit_ok;
  logic         bad_target;
  logic         req_fire;
  logic         keep;
  logic         pop;

  assign bad_target = redirect & (redirect_pc[1:0] != 2'b00);
  assign credit_ok  = ({1'b0, fifo_count} + {1'b0, outstanding}) < (CW+1)'(DEPTH);

  always_comb begin
    state_next     = state;
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;
    case (state)
      ST_FETCH: begin
        // armed holds requests off until the first edge after reset release.
        imem_req_valid = armed & !redirect & credit_ok;
        inst_valid     = !fifo_empty;
        if (bad_target) state_next = ST_HALT;
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
      default: state_next = ST_FETCH;
    endcase
  end

  assign req_fire      = imem_req_valid & imem_req_ready;
  assign keep          = imem_rsp_valid & (drop == '0) & !redirect & (state == ST_FETCH);
  assign pop           = inst_valid & inst_ready;
  assign push_entry    = '{pc: rsp_pc, word: imem_rsp_data};
  assign imem_req_addr = fpc;
  assign inst          = inst_valid ? head.word : INST_NOP;
  assign inst_pc       = head.pc;
  assign inst_pc4      = head.pc + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_FETCH;
      armed       <= 1'b0;
      fpc         <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      misaligned  <= 1'b0;
    end else begin
      state       <= state_next;
      armed       <= 1'b1;
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect) begin
        fpc    <= align_word(redirect_pc);
        rsp_pc <= align_word(redirect_pc);
        // Everything still in flight after this cycle belongs to the old path.
        drop   <= outstanding - CW'(imem_rsp_valid);
        if (bad_target) misaligned <= 1'b1;
      end else begin
        if (req_fire) fpc <= fpc + 32'd4;
        if (keep) rsp_pc <= rsp_pc + 32'd4;
        if (imem_rsp_valid && drop != '0) drop <= drop - CW'(1);
      end
    end
  end

  ifu_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (keep),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  a_no_rsp_underflow: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (outstanding != '0));
  a_drop_bounded: assert property (@(posedge clk) disable iff (rst)
    drop <= outstanding);
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(keep && fifo_full && !pop));

endmodule
